// File: rtl/fft_stream_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : fft_stream_wrapper
// Description : Streaming front/back end for a parallel FFT core. Collects
//               NPTS complex samples over a valid/ready input stream, hands
//               them to the core in parallel, pulses start, captures the
//               parallel result on done, and streams it back out with a last
//               marker and optional bit-reversed ordering.
// Revision    : 1.0 - initial counted, back-pressured framing
// ============================================================================
module fft_stream_wrapper #(
    parameter int NPTS       = 64,
    parameter int DW         = 16,
    parameter int OUT_BITREV = 0,
    parameter int IDX_W      = $clog2(NPTS)
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_re,
    input  logic [DW-1:0]        in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_re,
    output logic [DW-1:0]        out_im,
    output logic                 out_last,
    output logic                 busy,
    output logic [NPTS*DW-1:0]   core_in_re,
    output logic [NPTS*DW-1:0]   core_in_im,
    output logic                 core_start,
    input  logic                 core_done,
    input  logic [NPTS*DW-1:0]   core_out_re,
    input  logic [NPTS*DW-1:0]   core_out_im
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NPTS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_wr_idx;
    logic [IDX_W-1:0]    r_rd_idx;
    logic [IDX_W-1:0]    w_rd_sel;
    logic [NPTS*DW-1:0]  r_in_re;
    logic [NPTS*DW-1:0]  r_in_im;
    logic [NPTS*DW-1:0]  r_out_re;
    logic [NPTS*DW-1:0]  r_out_im;
    logic                w_accept;
    logic                w_capture;
    logic                w_out_fire;

    // abort wins over every same-cycle handshake, so it gates the strobes
    assign in_ready   = rstb & (r_state == S_LOAD) & ~abort;
    assign out_valid  = (r_state == S_DRAIN) & ~abort;
    assign core_start = (r_state == S_START) & ~abort;
    assign busy       = (r_state != S_LOAD);
    assign out_last   = out_valid & (r_rd_idx == c_last_idx);

    assign w_accept   = in_valid & in_ready;
    assign w_capture  = (r_state == S_WAIT) & core_done & ~abort;
    assign w_out_fire = out_valid & out_ready;

    // input buffer is only written in LOAD, so the core sees it stable afterwards
    assign core_in_re = r_in_re;
    assign core_in_im = r_in_im;

    // output read position: natural order or bit-reversed order
    generate
        if (OUT_BITREV != 0) begin : g_bitrev
            always_comb begin
                w_rd_sel = '0;
                for (int b = 0; b < IDX_W; b++) begin
                    w_rd_sel[b] = r_rd_idx[IDX_W-1-b];
                end
            end
        end else begin : g_linear
            assign w_rd_sel = r_rd_idx;
        end
    endgenerate

    assign out_re = out_valid ? r_out_re[w_rd_sel*DW +: DW] : '0;
    assign out_im = out_valid ? r_out_im[w_rd_sel*DW +: DW] : '0;

    // next-state decode; abort forces LOAD from any state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD:  if (w_accept && (r_wr_idx == c_last_idx)) w_state_next = S_START;
            S_START: w_state_next = S_WAIT;
            S_WAIT:  if (core_done) w_state_next = S_DRAIN;
            S_DRAIN: if (w_out_fire && (r_rd_idx == c_last_idx)) w_state_next = S_LOAD;
            default: w_state_next = S_LOAD;
        endcase
        if (abort) begin
            w_state_next = S_LOAD;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // write/read counters; abort discards any partial frame position
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
        end else if (abort) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
        end else begin
            if (w_accept) begin
                r_wr_idx <= (r_wr_idx == c_last_idx) ? '0 : r_wr_idx + 1'b1;
            end
            if (w_capture) begin
                r_rd_idx <= '0;
            end else if (w_out_fire) begin
                r_rd_idx <= (r_rd_idx == c_last_idx) ? '0 : r_rd_idx + 1'b1;
            end
        end
    end

    // sample buffers; contents survive abort and are simply overwritten later
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_in_re  <= '0;
            r_in_im  <= '0;
            r_out_re <= '0;
            r_out_im <= '0;
        end else begin
            if (w_accept) begin
                r_in_re[r_wr_idx*DW +: DW] <= in_re;
                r_in_im[r_wr_idx*DW +: DW] <= in_im;
            end
            if (w_capture) begin
                r_out_re <= core_out_re;
                r_out_im <= core_out_im;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_stream_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_stream_wrapper
// Description : Self-checking bench for fft_stream_wrapper. Two instances run
//               in lockstep (natural and bit-reversed output order), each with
//               its own core model returning in+100 three cycles after start.
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_fft_stream_wrapper;

    localparam int NPTS = 8;
    localparam int DW   = 16;

    logic clk = 1'b0;
    logic rstb, abort, in_valid, out_ready, force_done;
    logic [DW-1:0] in_re, in_im;

    logic in_ready0, out_valid0, out_last0, busy0, core_start0, core_done0;
    logic in_ready1, out_valid1, out_last1, busy1, core_start1, core_done1;
    logic [DW-1:0] out_re0, out_im0, out_re1, out_im1;
    logic [NPTS*DW-1:0] core_in_re0, core_in_im0, core_out_re0, core_out_im0;
    logic [NPTS*DW-1:0] core_in_re1, core_in_im1, core_out_re1, core_out_im1;

    logic [1:0] cnt0 = '0;
    logic [1:0] cnt1 = '0;
    int starts0 = 0;
    int starts1 = 0;
    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] fr_re [NPTS];
    logic [DW-1:0] fr_im [NPTS];

    always #5 clk = ~clk;

    fft_stream_wrapper #(.NPTS(NPTS), .DW(DW), .OUT_BITREV(0)) u_dut0 (
        .clk(clk), .rstb(rstb), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready0), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid0), .out_ready(out_ready), .out_re(out_re0), .out_im(out_im0),
        .out_last(out_last0), .busy(busy0),
        .core_in_re(core_in_re0), .core_in_im(core_in_im0), .core_start(core_start0),
        .core_done(core_done0), .core_out_re(core_out_re0), .core_out_im(core_out_im0)
    );

    fft_stream_wrapper #(.NPTS(NPTS), .DW(DW), .OUT_BITREV(1)) u_dut1 (
        .clk(clk), .rstb(rstb), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready1), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid1), .out_ready(out_ready), .out_re(out_re1), .out_im(out_im1),
        .out_last(out_last1), .busy(busy1),
        .core_in_re(core_in_re1), .core_in_im(core_in_im1), .core_start(core_start1),
        .core_done(core_done1), .core_out_re(core_out_re1), .core_out_im(core_out_im1)
    );

    // core model: every element +100, done pulse three cycles after start
    always_comb begin
        for (int i = 0; i < NPTS; i++) begin
            core_out_re0[i*DW +: DW] = core_in_re0[i*DW +: DW] + 16'd100;
            core_out_im0[i*DW +: DW] = core_in_im0[i*DW +: DW] + 16'd100;
            core_out_re1[i*DW +: DW] = core_in_re1[i*DW +: DW] + 16'd100;
            core_out_im1[i*DW +: DW] = core_in_im1[i*DW +: DW] + 16'd100;
        end
    end
    assign core_done0 = force_done | (cnt0 == 2'd1);
    assign core_done1 = force_done | (cnt1 == 2'd1);

    // core latency counters and start-pulse tallies
    always @(posedge clk) begin
        cnt0 <= core_start0 ? 2'd3 : ((cnt0 != 2'd0) ? cnt0 - 2'd1 : 2'd0);
        cnt1 <= core_start1 ? 2'd3 : ((cnt1 != 2'd0) ? cnt1 - 2'd1 : 2'd0);
        if (core_start0) starts0 <= starts0 + 1;
        if (core_start1) starts1 <= starts1 + 1;
    end

    // run-away guard
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int p);
        int r = 0;
        for (int b = 0; b < $clog2(NPTS); b++) begin
            if (((p >> b) & 1) != 0) r = r | (1 << ($clog2(NPTS) - 1 - b));
        end
        return r;
    endfunction

    // offer n samples from fr_* with random idle gaps; ends one negedge after the last accept
    task automatic send_frame(input int gap_pct, input int n);
        int k = 0;
        int g = 0;
        while (k < n && g < 400) begin
            @(negedge clk);
            g++;
            chk("in_ready_load", {31'b0, in_ready0}, 32'd1);
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_re = fr_re[k];
                in_im = fr_im[k];
                k++;
            end
        end
        chk("send_done", k, n);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // called on the cycle after the final accept: START must be showing
    task automatic check_start();
        chk("core_start0", {31'b0, core_start0}, 32'd1);
        chk("core_start1", {31'b0, core_start1}, 32'd1);
        chk("busy_start", {31'b0, busy0}, 32'd1);
        chk("in_ready_start", {31'b0, in_ready0}, 32'd0);
        for (int i = 0; i < NPTS; i++) begin
            chk("core_in_re0", {16'b0, core_in_re0[i*DW +: DW]}, {16'b0, fr_re[i]});
            chk("core_in_im0", {16'b0, core_in_im0[i*DW +: DW]}, {16'b0, fr_im[i]});
            chk("core_in_re1", {16'b0, core_in_re1[i*DW +: DW]}, {16'b0, fr_re[i]});
        end
        @(negedge clk);
        chk("core_start_width", {31'b0, core_start0}, 32'd0);
    endtask

    // drain with random stalls; returns early (out_ready low) at position stop_at
    task automatic drain(input int stall_pct, input int stop_at);
        int w = 0;
        while (!out_valid0 && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("drain_wait", {31'b0, out_valid0}, 32'd1);
        for (int p = 0; p < NPTS; p++) begin
            bit hs;
            int g;
            logic [DW-1:0] e0r, e0i, e1r, e1i;
            if (p == stop_at) begin
                out_ready = 1'b0;
                return;
            end
            e0r = fr_re[p] + 16'd100;
            e0i = fr_im[p] + 16'd100;
            e1r = fr_re[brev(p)] + 16'd100;
            e1i = fr_im[brev(p)] + 16'd100;
            hs = 1'b0;
            g = 0;
            while (!hs && g < 50) begin
                chk("out_valid0", {31'b0, out_valid0}, 32'd1);
                chk("out_re0", {16'b0, out_re0}, {16'b0, e0r});
                chk("out_im0", {16'b0, out_im0}, {16'b0, e0i});
                chk("out_last0", {31'b0, out_last0}, {31'b0, (p == NPTS - 1)});
                chk("out_valid1", {31'b0, out_valid1}, 32'd1);
                chk("out_re1", {16'b0, out_re1}, {16'b0, e1r});
                chk("out_im1", {16'b0, out_im1}, {16'b0, e1i});
                chk("out_last1", {31'b0, out_last1}, {31'b0, (p == NPTS - 1)});
                chk("in_ready_drain", {31'b0, in_ready0}, 32'd0);
                hs = ($urandom_range(99) >= stall_pct);
                out_ready = hs;
                @(negedge clk);
                g++;
            end
            chk("drain_progress", {31'b0, hs}, 32'd1);
        end
        out_ready = 1'b0;
        chk("busy_after_last0", {31'b0, busy0}, 32'd0);
        chk("busy_after_last1", {31'b0, busy1}, 32'd0);
        chk("out_valid_after_last", {31'b0, out_valid0}, 32'd0);
        chk("in_ready_after_last", {31'b0, in_ready0}, 32'd1);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < NPTS; i++) begin
            fr_re[i] = DW'($urandom);
            fr_im[i] = DW'($urandom);
        end
    endtask

    initial begin
        int s0;
        int s1;
        rstb = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        force_done = 1'b0; in_re = '0; in_im = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready0}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("rst_busy", {31'b0, busy0}, 32'd0);
        chk("rst_core_start", {31'b0, core_start0}, 32'd0);
        chk("rst_out_last", {31'b0, out_last0}, 32'd0);
        chk("rst_out_re", {16'b0, out_re0}, 32'd0);
        chk("rst_core_in", core_in_re0[31:0], 32'd0);
        rstb = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready0}, 32'd1);

        // directed ramp frame, continuous valid and ready
        for (int i = 0; i < NPTS; i++) begin
            fr_re[i] = DW'(i);
            fr_im[i] = DW'(-i);
        end
        s0 = starts0; s1 = starts1;
        send_frame(0, NPTS);
        check_start();
        drain(0, 99);
        chk("one_start0", starts0 - s0, 1);
        chk("one_start1", starts1 - s1, 1);

        // random data with input gaps and output stalls
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_frame(50, NPTS);
            check_start();
            drain(50, 99);
        end

        // abandon a partial frame, then a full replacement frame
        for (int i = 0; i < NPTS; i++) fr_re[i] = DW'(50 + i);
        s0 = starts0;
        send_frame(0, 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'b0, busy0}, 32'd0);
        rand_frame();
        for (int i = 0; i < NPTS; i++) fr_re[i] = DW'(20 + i);
        send_frame(30, NPTS);
        check_start();
        drain(0, 99);
        chk("abort_one_start", starts0 - s0, 1);

        // asynchronous reset in the middle of a drain
        rand_frame();
        send_frame(0, NPTS);
        check_start();
        drain(0, 3);
        rstb = 1'b0;
        #1;
        chk("async_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("async_busy", {31'b0, busy0}, 32'd0);
        chk("async_out_last", {31'b0, out_last0}, 32'd0);
        chk("async_in_ready", {31'b0, in_ready0}, 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        #1;
        chk("rerst_in_ready", {31'b0, in_ready0}, 32'd1);
        rand_frame();
        send_frame(20, NPTS);
        check_start();
        drain(20, 99);

        // core_done held high from reset: capture on the first WAIT cycle only
        rstb = 1'b0;
        force_done = 1'b1;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        for (int f = 0; f < 2; f++) begin
            rand_frame();
            send_frame(0, NPTS);
            check_start();
            chk("done_wait_no_valid", {31'b0, out_valid0}, 32'd0);
            @(negedge clk);
            chk("done_capture_valid", {31'b0, out_valid0}, 32'd1);
            drain(0, 99);
        end
        force_done = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_stream_wrapper.md
Name: fft_stream_wrapper

Overview:
Parametrised streaming front/back end for the FFT core. It collects NPTS complex samples over a valid/ready input stream and presents them in parallel to the core. It pulses the core start and captures the core's parallel result on done. It then streams the result out over a valid/ready output stream with a last marker and optional bit-reversed output ordering. It replaces fixed 64-point shift-register framing with counted, back-pressured framing.

Parameters:
NPTS, 64, FFT points per frame; power of two, 4..1024
DW, 16, bits per real/imag component (two's complement, passed through unmodified)
OUT_BITREV, 0, 0: output index k emitted at position k; 1: position p emits buf[bitrev(p)]
IDX_W, $clog2(NPTS), sample index width (derived; not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rstb  in  1  asynchronous active-low reset
abort  in  1  synchronous frame abandon
in_valid  in  1  input sample valid
in_ready  out  1  wrapper accepts input sample
in_re  in  DW  input real
in_im  in  DW  input imag
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output sample
out_re  out  DW  output real
out_im  out  DW  output imag
out_last  out  1  final sample of frame (with out_valid)
busy  out  1  high in any state but LOAD
core_in_re  out  NPTS*DW  parallel to core; sample i at [i*DW +: DW]
core_in_im  out  NPTS*DW  as above
core_start  out  1  one-cycle start pulse to core
core_done  in  1  core result valid (level or pulse)
core_out_re  in  NPTS*DW  core result real, same packing
core_out_im  in  NPTS*DW  core result imag

Behaviour:
- Reset (rstb low, async): state=LOAD, wr_idx=0, rd_idx=0, in/out buffers all 0; in_ready=0 while rstb low, then 1 from first edge-free cycle in LOAD; out_valid=0, out_last=0, core_start=0, busy=0, out_re/out_im=0.
- FSM LOAD -> START -> WAIT -> DRAIN -> LOAD.
- LOAD: in_ready=1. On in_valid&in_ready, inbuf[wr_idx]<={in_re,in_im} and wr_idx++. On the accept with wr_idx==NPTS-1: wr_idx<=0, go START. First accepted sample lands at index 0.
- START: core_start=1 for exactly this one cycle; core_in_* held stable from START until LOAD re-entered; go WAIT.
- WAIT: on core_done=1, outbuf<=core_out_*, rd_idx<=0, go DRAIN. No timeout. core_done outside WAIT is ignored.
- DRAIN: out_valid=1; out_re/out_im=outbuf[OUT_BITREV ? bitrev(rd_idx) : rd_idx] (registered buffer, combinational mux). On out_valid&out_ready: rd_idx++. out_last=1 when rd_idx==NPTS-1. Handshake on last: rd_idx<=0, go LOAD. While out_ready=0, out_* and out_last hold stable.
- in_ready=0 in START/WAIT/DRAIN; no overlap between frames.
- abort=1 (any state): next state LOAD, wr_idx=rd_idx=0, out_valid=0, core_start=0. Buffers are not cleared. abort has priority over same-cycle accept, done, or output handshake; an abandoned partial frame is discarded.
- Simultaneous core_done on START cycle: ignored (only sampled in WAIT).
- Throughput: NPTS input cycles + 1 START + core latency + 1 capture + NPTS output cycles, with no back-pressure.

Test Plan:
- NPTS=8, OUT_BITREV=0: stream samples re=i, im=-i for i=0..7, continuous valid. Core model returns out=in+100 after 3 cycles. -> core_start single pulse exactly 1 cycle after 8th accept; out emits re=100..107, im=100,99..93 in order; out_last only with re=107; busy low after last handshake.
- OUT_BITREV=1, NPTS=8, same data -> output re sequence 100,104,102,106,101,105,103,107.
- Random in_valid gaps and out_ready stalls (50%) -> no sample lost/duplicated; out_* stable during stall; in_ready=0 throughout DRAIN.
- abort after 5 of 8 inputs, then 8 new samples re=20..27 -> core_in_re index 0..7 = 20..27; exactly one core_start.
- rstb asserted mid-DRAIN at rd_idx=3 -> out_valid, busy, out_last=0 immediately (async); after release, in_ready=1 and next frame processes normally.
- core_done held high continuously from reset -> ignored in LOAD/START; capture occurs on first WAIT cycle; second frame also captures correctly.
